mul_ctrl: RTL and testbench
===========================

Name: mul_ctrl

Overview:
- Control FSM for the repeated-addition multiplier datapath: A register, B down-counter, P accumulator/adder, and the zero-detector on B.
- Accepts two operand beats (A, then B) on the shared 16-bit data bus.
- Each cycle that the B zero flag is low, adds A into P and decrements B; stops when B reaches zero.
- Reports done/error through a done/ack handshake. Emits only datapath control strobes; no data passes through this block.

Parameters:
- CNT_W, 16, width of the iteration counter and of the iter_count output; matches datapath width.
- MAX_ITER, 65535, watchdog limit on add iterations per operation; reaching it without eqz aborts with err.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request new multiplication; sampled in IDLE only.
- data_valid  in  1  operand beat present on datapath bus this cycle.
- eqz  in  1  zero flag of B register (combinational from B register output).
- ldA  out  1  load A register from bus.
- ldB  out  1  load B counter from bus.
- clrP  out  1  clear P accumulator.
- ldP  out  1  P <= P + A this cycle.
- decB  out  1  B <= B - 1 this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  result valid in P; held until ack.
- err  out  1  watchdog abort flag; valid while done=1.
- ack  in  1  consumer accepted result.
- iter_count  out  CNT_W  number of add iterations performed in current/last operation.

Behaviour:
- States: IDLE, LOAD_A, LOAD_B, RUN, DONE. State is registered; strobes are combinational from state plus inputs (Mealy).
- Reset: rst=1 at a clk edge forces IDLE and clears iter_count and err_reg, even mid-operation. While in IDLE, all strobes, busy and done are 0.
- IDLE:
  - start=1 -> LOAD_A.
  - start while busy is ignored (not queued).
- LOAD_A:
  - Waits indefinitely for data_valid.
  - On data_valid=1: ldA=1 and clrP=1 in that cycle; clear iter_count and err_reg; -> LOAD_B.
- LOAD_B:
  - On data_valid=1: ldB=1; -> RUN.
  - The A beat and B beat therefore require at least two distinct cycles.
- RUN, per cycle:
  - If eqz=1 -> DONE with no strobes.
  - Else if iter_count==MAX_ITER -> DONE with err_reg set, no strobes.
  - Else ldP=1, decB=1, iter_count+1; stay in RUN.
  - B=0 loaded: 1 RUN cycle, P stays 0.
  - B=n: n+1 RUN cycles; P=A*n (mod 2^16, wrap per datapath adder).
- DONE:
  - done=1, err=err_reg, busy=1.
  - ack=1 -> IDLE on next edge; done drops then.
  - ack is ignored outside DONE.
  - start is ignored in DONE.
- Latency from start to done (data_valid held high): 1 (LOAD_A) + 1 (LOAD_B) + B+1 (RUN) cycles after the start edge. done is first seen B+3 cycles after IDLE samples start.
- iter_count saturates at MAX_ITER and holds its value through DONE and IDLE until the next LOAD_A beat.
- data_valid is ignored in IDLE, RUN and DONE.

Decomposition:
- Package mul_pkg holds:
  - state enum type mul_state_t (IDLE, LOAD_A, LOAD_B, RUN, DONE);
  - DATA_W=16 constant shared with the datapath and EQZ.
- Sub-module mul_iter_cnt: CNT_W counter with clear, increment and terminal-count (==MAX_ITER) output.
- FSM and output decode stay in mul_ctrl.

Test Plan:
The bench instantiates the A/B/P datapath model plus EQZ on B.
1. A=7, B=5, data_valid high, start pulse:
   - ldA and ldB on consecutive cycles; 5 cycles of ldP and decB;
   - done 8 cycles after start sampled; P=35, iter_count=5, err=0.
2. A=9, B=0:
   - RUN lasts 1 cycle with no ldP; done with P=0, iter_count=0.
3. Stalled operands: A=3, data_valid low for 4 cycles in LOAD_A and 2 in LOAD_B, B=4:
   - FSM waits; then P=12.
   - Hold done 3 cycles, then ack -> IDLE next edge.
4. MAX_ITER=3, A=2, B=10:
   - exactly 3 ldP/decB cycles; done=1 with err=1, iter_count=3, P=6.
5. rst asserted in RUN after 2 iterations (A=4, B=6):
   - next edge IDLE, busy=0, iter_count=0.
   - A new start with A=4, B=2 yields P=8, err=0.
6. start pulsed during RUN and during DONE, and ack pulsed in RUN:
   - no state effect; the operation completes normally.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier control slice.
package mul_pkg;

    // Width of the shared operand bus, the A/B/P registers and the EQZ detector.
    localparam int unsigned DATA_W = 16;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } mul_state_t;

endpackage

// File: rtl/mul_iter_cnt.sv
// Add-iteration counter: synchronous clear, saturating increment, terminal-count flag.
module mul_iter_cnt #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_ITER = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_max;

    assign at_max  = (count_q == CNT_W'(MAX_ITER));
    assign tc_o    = at_max;
    assign count_o = count_q;

    // Next count: clear wins over increment; increment stops at MAX_ITER.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !at_max) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mul_ctrl.sv
// Control FSM for the repeated-addition multiplier (A reg, B down-counter, P accumulator).
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_ITER = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             data_valid,
    input  logic             eqz,
    output logic             ldA,
    output logic             ldB,
    output logic             clrP,
    output logic             ldP,
    output logic             decB,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             ack,
    output logic [CNT_W-1:0] iter_count
);

    mul_state_t state_q;
    mul_state_t state_d;
    logic       err_q;
    logic       err_d;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       cnt_tc;

    mul_iter_cnt #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .count_o (iter_count),
        .tc_o    (cnt_tc)
    );

    // Next-state and Mealy strobe decode; every output defaults to inactive.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        ldA     = 1'b0;
        ldB     = 1'b0;
        clrP    = 1'b0;
        ldP     = 1'b0;
        decB    = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        err     = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                if (data_valid) begin
                    ldA     = 1'b1;
                    clrP    = 1'b1;
                    cnt_clr = 1'b1;
                    err_d   = 1'b0;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (data_valid) begin
                    ldB     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Zero test takes priority so B == MAX_ITER completes without error.
                if (eqz) begin
                    state_d = DONE;
                end else if (cnt_tc) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    ldP     = 1'b1;
                    decB    = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                done = 1'b1;
                err  = err_q;
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and error-flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a behavioural A/B/P datapath and EQZ on B.
module tb_mul_ctrl;
    import mul_pkg::*;

    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst;
    logic data_valid;
    logic [DATA_W-1:0] bus;

    // Instance 1: default watchdog.
    logic start1, ack1, eqz1;
    logic ldA1, ldB1, clrP1, ldP1, decB1, busy1, done1, err1;
    logic [CNT_W-1:0] iter1;
    logic [DATA_W-1:0] a1_q, b1_q, p1_q;

    // Instance 2: watchdog limit of 3.
    logic start2, ack2, eqz2;
    logic ldA2, ldB2, clrP2, ldP2, decB2, busy2, done2, err2;
    logic [CNT_W-1:0] iter2;
    logic [DATA_W-1:0] a2_q, b2_q, p2_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_ctrl #(.CNT_W(CNT_W), .MAX_ITER(65535)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data_valid(data_valid), .eqz(eqz1),
        .ldA(ldA1), .ldB(ldB1), .clrP(clrP1), .ldP(ldP1), .decB(decB1),
        .busy(busy1), .done(done1), .err(err1), .ack(ack1), .iter_count(iter1)
    );

    mul_ctrl #(.CNT_W(CNT_W), .MAX_ITER(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .data_valid(data_valid), .eqz(eqz2),
        .ldA(ldA2), .ldB(ldB2), .clrP(clrP2), .ldP(ldP2), .decB(decB2),
        .busy(busy2), .done(done2), .err(err2), .ack(ack2), .iter_count(iter2)
    );

    // Datapath models.
    assign eqz1 = (b1_q == '0);
    assign eqz2 = (b2_q == '0);

    always @(posedge clk) begin
        if (ldA1) a1_q <= bus;
        if (ldB1) b1_q <= bus;
        else if (decB1) b1_q <= b1_q - 1'b1;
        if (clrP1) p1_q <= '0;
        else if (ldP1) p1_q <= p1_q + a1_q;
        if (ldA2) a2_q <= bus;
        if (ldB2) b2_q <= bus;
        else if (decB2) b2_q <= b2_q - 1'b1;
        if (clrP2) p2_q <= '0;
        else if (ldP2) p2_q <= p2_q + a2_q;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs until done of the selected instance, counting cycles and ldP strobes.
    task automatic wait_done(input bit sel, input int budget, output int cycles, output int nldp);
        cycles = 0;
        nldp   = 0;
        while (!(sel ? done2 : done1) && cycles < budget) begin
            if (sel ? ldP2 : ldP1) nldp++;
            if ((sel ? ldP2 : ldP1) !== (sel ? decB2 : decB1)) chk("ldP_decB_pair", 0, 1);
            step();
            cycles++;
        end
        chk("done_within_budget", {31'd0, (sel ? done2 : done1)}, 1);
    endtask

    int cyc, nldp;

    initial begin
        rst = 1'b1; data_valid = 1'b0; bus = '0;
        start1 = 1'b0; ack1 = 1'b0; start2 = 1'b0; ack2 = 1'b0;
        a1_q = '0; b1_q = '0; p1_q = '0; a2_q = '0; b2_q = '0; p2_q = '0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("reset_busy", {31'd0, busy1}, 0);
        chk("reset_done", {31'd0, done1}, 0);
        chk("reset_iter", {16'd0, iter1}, 0);
        chk("reset_strobes", {27'd0, ldA1, ldB1, clrP1, ldP1, decB1}, 0);

        // Test 1: A=7, B=5, data_valid held high.
        start1 = 1'b1; data_valid = 1'b1; bus = 16'd7;
        #1 chk("t1_idle_no_ldA", {31'd0, ldA1}, 0);
        step();
        start1 = 1'b0;
        #1;
        chk("t1_ldA", {31'd0, ldA1}, 1);
        chk("t1_clrP", {31'd0, clrP1}, 1);
        chk("t1_busy", {31'd0, busy1}, 1);
        step();
        bus = 16'd5;
        #1;
        chk("t1_ldB", {31'd0, ldB1}, 1);
        chk("t1_no_ldA_in_loadb", {31'd0, ldA1}, 0);
        step();
        wait_done(1'b0, 100, cyc, nldp);
        chk("t1_latency", cyc + 2, 8);
        chk("t1_nldp", nldp, 5);
        chk("t1_P", {16'd0, p1_q}, 35);
        chk("t1_iter", {16'd0, iter1}, 5);
        chk("t1_err", {31'd0, err1}, 0);
        chk("t1_no_strobe_done", {27'd0, ldA1, ldB1, clrP1, ldP1, decB1}, 0);
        ack1 = 1'b1;
        step();
        ack1 = 1'b0;
        #1;
        chk("t1_idle_busy", {31'd0, busy1}, 0);
        chk("t1_idle_done", {31'd0, done1}, 0);
        chk("t1_iter_held", {16'd0, iter1}, 5);

        // Test 2: A=9, B=0.
        start1 = 1'b1; bus = 16'd9;
        step(); start1 = 1'b0;
        step(); bus = 16'd0;
        step();
        wait_done(1'b0, 20, cyc, nldp);
        chk("t2_run_cycles", cyc, 1);
        chk("t2_nldp", nldp, 0);
        chk("t2_P", {16'd0, p1_q}, 0);
        chk("t2_iter", {16'd0, iter1}, 0);
        ack1 = 1'b1; step(); ack1 = 1'b0;

        // Test 3: stalled operands, A=3, B=4.
        data_valid = 1'b0; bus = 16'd3;
        start1 = 1'b1; step(); start1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t3_wait_a_no_ldA", {31'd0, ldA1}, 0);
            step();
        end
        chk("t3_busy_waiting", {31'd0, busy1}, 1);
        data_valid = 1'b1;
        #1 chk("t3_ldA", {31'd0, ldA1}, 1);
        step();
        data_valid = 1'b0; bus = 16'd4;
        for (int i = 0; i < 2; i++) begin
            #1 chk("t3_wait_b_no_ldB", {31'd0, ldB1}, 0);
            step();
        end
        data_valid = 1'b1;
        #1 chk("t3_ldB", {31'd0, ldB1}, 1);
        step();
        data_valid = 1'b0;
        wait_done(1'b0, 50, cyc, nldp);
        chk("t3_P", {16'd0, p1_q}, 12);
        chk("t3_iter", {16'd0, iter1}, 4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_done_held", {31'd0, done1}, 1);
        end
        ack1 = 1'b1; step(); ack1 = 1'b0;
        #1;
        chk("t3_idle_after_ack", {30'd0, busy1, done1}, 0);

        // Test 4: watchdog instance, A=2, B=10.
        data_valid = 1'b1; bus = 16'd2;
        start2 = 1'b1; step(); start2 = 1'b0;
        step(); bus = 16'd10;
        step();
        wait_done(1'b1, 50, cyc, nldp);
        chk("t4_nldp", nldp, 3);
        chk("t4_err", {31'd0, err2}, 1);
        chk("t4_iter", {16'd0, iter2}, 3);
        chk("t4_P", {16'd0, p2_q}, 6);
        chk("t4_inst1_idle", {31'd0, busy1}, 0);
        ack2 = 1'b1; step(); ack2 = 1'b0;
        #1 chk("t4_idle", {31'd0, busy2}, 0);

        // Test 5: reset in RUN after 2 iterations (A=4, B=6), then A=4, B=2.
        bus = 16'd4;
        start1 = 1'b1; step(); start1 = 1'b0;
        step(); bus = 16'd6;
        step();
        step(); step();
        chk("t5_iter_before_rst", {16'd0, iter1}, 2);
        rst = 1'b1; step(); rst = 1'b0;
        #1;
        chk("t5_rst_busy", {31'd0, busy1}, 0);
        chk("t5_rst_iter", {16'd0, iter1}, 0);
        chk("t5_rst_done", {31'd0, done1}, 0);
        bus = 16'd4;
        start1 = 1'b1; step(); start1 = 1'b0;
        step(); bus = 16'd2;
        step();
        wait_done(1'b0, 50, cyc, nldp);
        chk("t5_P", {16'd0, p1_q}, 8);
        chk("t5_err", {31'd0, err1}, 0);
        chk("t5_iter", {16'd0, iter1}, 2);
        ack1 = 1'b1; step(); ack1 = 1'b0;

        // Test 6: start/ack pulses during RUN, start during DONE (A=6, B=3).
        bus = 16'd6;
        start1 = 1'b1; step(); start1 = 1'b0;
        step(); bus = 16'd3;
        step();
        start1 = 1'b1; step(); start1 = 1'b0;
        ack1 = 1'b1; step(); ack1 = 1'b0;
        #1 chk("t6_still_running", {30'd0, busy1, done1}, 2);
        wait_done(1'b0, 50, cyc, nldp);
        chk("t6_nldp_after_pulses", nldp, 1);
        chk("t6_P", {16'd0, p1_q}, 18);
        chk("t6_iter", {16'd0, iter1}, 3);
        start1 = 1'b1; step(); start1 = 1'b0;
        #1 chk("t6_done_after_start", {31'd0, done1}, 1);
        ack1 = 1'b1; step(); ack1 = 1'b0;
        #1 chk("t6_idle", {31'd0, busy1}, 0);
        step();
        chk("t6_start_not_queued", {31'd0, busy1}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
